// File: rtl/uart_fifo_ctrl.sv
// UART transceiver: baud generator, 16x RX, TX, TX/RX FIFOs, echo mode.
// Optional even parity frame bit enabled by defining UART_PARITY_EN.
`timescale 1ns/1ps

module uart_fifo_ctrl_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  logic [AW:0]  wnext, rnext, fill;
  logic         do_push, do_pop;

  // push+pop at full or empty is accepted so occupancy stays put
  always_comb begin
    do_push = push && (!full || pop);
    do_pop  = pop && (!empty || push);
    wnext   = do_push ? wptr + (AW+1)'(1) : wptr;
    rnext   = do_pop ? rptr + (AW+1)'(1) : rptr;
    fill    = wnext - rnext;
  end

  // pointers and registered status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      wptr  <= wnext;
      rptr  <= rnext;
      full  <= (fill == (AW+1)'(DEPTH));
      empty <= (wnext == rnext);
    end
  end

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rptr[AW-1:0]];
endmodule

module uart_fifo_ctrl #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 tx,
  input  logic [DATA_BITS-1:0] tx_wdata,
  input  logic                 tx_push,
  output logic                 tx_full,
  output logic                 tx_busy,
  output logic [DATA_BITS-1:0] rx_rdata,
  input  logic                 rx_pop,
  output logic                 rx_empty,
  input  logic                 echo_en,
  output logic                 rx_overflow,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err
);
  localparam int DIV = CLK_FREQ / (BAUD * 16);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [2:0] LAST = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } st_t;

  logic [CW-1:0] bcnt;
  logic          tick;

  // free-running baud counter, tick on its last count
  always_ff @(posedge clk) begin
    if (rst) bcnt <= '0;
    else if (tick) bcnt <= '0;
    else bcnt <= bcnt + CW'(1);
  end

  assign tick = (bcnt == CW'(DIV - 1));

  logic rx_m, rx_s;

  // two-flop synchronizer for the asynchronous line
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  logic                 txf_push, txf_pop, txf_full, txf_empty;
  logic [DATA_BITS-1:0] txf_wdata, txf_rdata;
  logic                 rx_wr;
  logic [DATA_BITS-1:0] rx_byte;
  logic                 rxf_full;

  assign txf_push  = echo_en ? rx_wr : tx_push;
  assign txf_wdata = echo_en ? rx_byte : tx_wdata;

  uart_fifo_ctrl_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_txf (
    .clk   (clk),
    .rst   (rst),
    .push  (txf_push),
    .wdata (txf_wdata),
    .pop   (txf_pop),
    .rdata (txf_rdata),
    .full  (txf_full),
    .empty (txf_empty)
  );

  uart_fifo_ctrl_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rxf (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_wr),
    .wdata (rx_byte),
    .pop   (rx_pop),
    .rdata (rx_rdata),
    .full  (rxf_full),
    .empty (rx_empty)
  );

  assign tx_full = txf_full;

  st_t                  tx_st;
  logic [3:0]           tcnt;
  logic [2:0]           tbit;
  logic [DATA_BITS-1:0] tsh;
`ifdef UART_PARITY_EN
  logic                 tpar;
`endif

  assign txf_pop = tick && (tx_st == IDLE) && !txf_empty;

  // transmitter: frames start only on tick boundaries
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st   <= IDLE;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tcnt    <= '0;
      tbit    <= '0;
      tsh     <= '0;
`ifdef UART_PARITY_EN
      tpar    <= 1'b0;
`endif
    end else if (tick) begin
      unique case (tx_st)
        IDLE: begin
          if (!txf_empty) begin
            tsh     <= txf_rdata;
`ifdef UART_PARITY_EN
            tpar    <= ^txf_rdata;
`endif
            tx_st   <= START;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
            tcnt    <= '0;
          end
        end
        START: begin
          tcnt <= tcnt + 4'd1;
          if (tcnt == 4'd15) begin
            tx_st <= DATA;
            tx    <= tsh[0];
            tsh   <= tsh >> 1;
            tbit  <= '0;
          end
        end
        DATA: begin
          tcnt <= tcnt + 4'd1;
          if (tcnt == 4'd15) begin
            if (tbit == LAST) begin
`ifdef UART_PARITY_EN
              tx_st <= PARITY;
              tx    <= tpar;
`else
              tx_st <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              tx   <= tsh[0];
              tsh  <= tsh >> 1;
              tbit <= tbit + 3'd1;
            end
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          tcnt <= tcnt + 4'd1;
          if (tcnt == 4'd15) begin
            tx_st <= STOP;
            tx    <= 1'b1;
          end
        end
`endif
        STOP: begin
          tcnt <= tcnt + 4'd1;
          if (tcnt == 4'd15) begin
            tx_st   <= IDLE;
            tx_busy <= 1'b0;
          end
        end
        default: tx_st <= IDLE;
      endcase
    end
  end

  st_t                  rx_st;
  logic [3:0]           rcnt;
  logic [2:0]           rbit;
  logic [DATA_BITS-1:0] rsh;
`ifdef UART_PARITY_EN
  logic                 par_bad;
  logic                 parity_err;
`endif

  // receiver: mid-bit sampling, frame checks, FIFO write strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st        <= IDLE;
      rcnt         <= '0;
      rbit         <= '0;
      rsh          <= '0;
      rx_wr        <= 1'b0;
      rx_byte      <= '0;
      rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      par_bad      <= 1'b0;
      parity_err   <= 1'b0;
`endif
    end else begin
      rx_wr        <= 1'b0;
      rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      parity_err   <= 1'b0;
`endif
      unique case (rx_st)
        IDLE: begin
          if (!rx_s) begin
            rx_st <= START;
            rcnt  <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (rcnt == 4'd7) begin
              rcnt <= '0;
              rbit <= '0;
`ifdef UART_PARITY_EN
              par_bad <= 1'b0;
`endif
              rx_st <= rx_s ? IDLE : DATA;
            end else begin
              rcnt <= rcnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            rcnt <= rcnt + 4'd1;
            if (rcnt == 4'd15) begin
              rsh  <= {rx_s, rsh[DATA_BITS-1:1]};
              rbit <= rbit + 3'd1;
              if (rbit == LAST) begin
`ifdef UART_PARITY_EN
                rx_st <= PARITY;
`else
                rx_st <= STOP;
`endif
              end
            end
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (tick) begin
            rcnt <= rcnt + 4'd1;
            if (rcnt == 4'd15) begin
              par_bad <= rx_s ^ (^rsh);
              rx_st   <= STOP;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            rcnt <= rcnt + 4'd1;
            if (rcnt == 4'd15) begin
              rx_st <= IDLE;
              if (!rx_s) begin
                rx_frame_err <= 1'b1;
`ifdef UART_PARITY_EN
              end else if (par_bad) begin
                parity_err <= 1'b1;
`endif
              end else begin
                rx_wr   <= 1'b1;
                rx_byte <= rsh;
              end
            end
          end
        end
        default: rx_st <= IDLE;
      endcase
    end
  end

`ifdef UART_PARITY_EN
  assign rx_parity_err = parity_err;
`else
  assign rx_parity_err = 1'b0;
`endif

  // lost-byte pulse when the RX FIFO cannot take the write
  always_ff @(posedge clk) begin
    if (rst) rx_overflow <= 1'b0;
    else rx_overflow <= rx_wr && rxf_full && !rx_pop;
  end
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Self-checking bench for uart_fifo_ctrl using a fast baud setting.
// Serial frames are built and decoded from the line format directly.
`timescale 1ns/1ps

module tb_uart_fifo_ctrl;
  localparam int CLK_FREQ = 3_200_000;
  localparam int BAUD     = 100_000;
  localparam int DB       = 8;
  localparam int DEPTH    = 16;
  localparam int BITCLK   = (CLK_FREQ / (BAUD * 16)) * 16;
`ifdef UART_PARITY_EN
  localparam int NB = DB + 3;
`else
  localparam int NB = DB + 2;
`endif

  logic          clk = 1'b0;
  logic          rst, rx, tx;
  logic [DB-1:0] tx_wdata, rx_rdata;
  logic          tx_push, tx_full, tx_busy;
  logic          rx_pop, rx_empty, echo_en;
  logic          rx_overflow, rx_frame_err, rx_parity_err;

  uart_fifo_ctrl #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .DATA_BITS  (DB),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .tx            (tx),
    .tx_wdata      (tx_wdata),
    .tx_push       (tx_push),
    .tx_full       (tx_full),
    .tx_busy       (tx_busy),
    .rx_rdata      (rx_rdata),
    .rx_pop        (rx_pop),
    .rx_empty      (rx_empty),
    .echo_en       (echo_en),
    .rx_overflow   (rx_overflow),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ovf_n = 0, ferr_n = 0, perr_n = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rx_overflow === 1'b1) ovf_n <= ovf_n + 1;
    if (rx_frame_err === 1'b1) ferr_n <= ferr_n + 1;
    if (rx_parity_err === 1'b1) perr_n <= perr_n + 1;
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop,
                           input bit bad_par, input bit chk);
    rx = 1'b0;
    repeat (BITCLK) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rx = b[i];
      repeat (BITCLK) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    rx = (^b) ^ bad_par;
    repeat (BITCLK) @(negedge clk);
`endif
    if (bad_stop) begin
      rx = 1'b0;
      repeat (BITCLK * 3 / 4) @(negedge clk);
      rx = 1'b1;
      repeat (BITCLK / 4 + 2 * BITCLK) @(negedge clk);
    end else begin
      rx = 1'b1;
      if (chk) check("rx_empty_pre_stop", rx_empty, 1);
      repeat (BITCLK * 7 / 8) @(negedge clk);
      if (chk) check("rx_empty_mid_stop", rx_empty, 0);
      repeat (BITCLK / 8) @(negedge clk);
    end
  endtask

  task automatic tx_get(input int budget, output logic [7:0] b,
                        output bit ok);
    int n;
    ok = 1'b0;
    b  = '0;
    n  = 0;
    while (tx !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) return;
    repeat (BITCLK / 2) @(negedge clk);
    if (tx !== 1'b0) return;
    for (int i = 0; i < DB; i++) begin
      repeat (BITCLK) @(negedge clk);
      b[i] = tx;
    end
`ifdef UART_PARITY_EN
    repeat (BITCLK) @(negedge clk);
    if (tx !== ^b) return;
`endif
    repeat (BITCLK) @(negedge clk);
    if (tx !== 1'b1) return;
    ok = 1'b1;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check(tag, rx_rdata, exp);
    rx_pop = 1'b1;
    @(negedge clk);
    rx_pop = 1'b0;
  endtask

  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic [7:0] got, got2, v;
  bit         ok, ok2;
  int         t0, n, base;

  initial begin
    rst = 1'b1; rx = 1'b1; tx_wdata = '0; tx_push = 1'b0;
    rx_pop = 1'b0; echo_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_full", tx_full, 0);
    check("rst_empty", rx_empty, 1);
    check("rst_rdata", rx_rdata, 0);
    check("rst_errs", {rx_overflow, rx_frame_err, rx_parity_err}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // single byte 0x55: start length, bit order, busy duration
    tx_push = 1'b1; tx_wdata = 8'h55;
    @(negedge clk);
    tx_push = 1'b0;
    n = 0;
    while (tx !== 1'b0 && n < 4 * BITCLK) begin @(negedge clk); n++; end
    check("tx55_start_seen", tx, 0);
    t0 = cyc;
    check("tx55_busy", tx_busy, 1);
    n = 0;
    while (tx === 1'b0 && n < 2 * BITCLK) begin @(negedge clk); n++; end
    check("tx55_start_len", n, BITCLK);
    v = 8'h55;
    repeat (BITCLK / 2) @(negedge clk);
    got[0] = tx;
    for (int i = 1; i < DB; i++) begin
      repeat (BITCLK) @(negedge clk);
      got[i] = tx;
    end
    check("tx55_data", got, v);
    n = 0;
    while (tx_busy === 1'b1 && n < 4 * BITCLK) begin @(negedge clk); n++; end
    check("tx55_busy_len", cyc - t0, NB * BITCLK);
    check("tx55_idle_line", tx, 1);

    // burst of 20 pushes: one goes to the shifter, 16 fill the FIFO
    txq.delete();
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          v = 8'($urandom);
          if (i < DEPTH + 1) txq.push_back(v);
          tx_push = 1'b1; tx_wdata = v;
          @(negedge clk);
        end
        tx_push = 1'b0;
        check("tx_full_burst", tx_full, 1);
      end
      begin
        for (int i = 0; i < DEPTH + 1; i++) begin
          tx_get(3 * NB * BITCLK, got, ok);
          check("txb_frame_ok", ok, 1);
          check("txb_data", got, txq[i]);
        end
      end
    join
    tx_get(3 * NB * BITCLK, got, ok);
    check("txb_no_extra", ok, 0);
    check("txb_not_full", tx_full, 0);

    // reset mid-frame aborts the shifter and flushes the queue
    tx_push = 1'b1; tx_wdata = 8'hA5;
    @(negedge clk);
    tx_wdata = 8'h5A;
    @(negedge clk);
    tx_push = 1'b0;
    n = 0;
    while (tx !== 1'b0 && n < 4 * BITCLK) begin @(negedge clk); n++; end
    repeat (BITCLK + 7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_tx", tx, 1);
    check("midrst_busy", tx_busy, 0);
    tx_get(3 * NB * BITCLK, got, ok);
    check("midrst_no_frame", ok, 0);

    // RX 0xA3 with timing of the empty flag around the stop bit
    send_byte(8'hA3, 1'b0, 1'b0, 1'b1);
    pop_check("rxA3_data", 8'hA3);
    check("rxA3_empty_after", rx_empty, 1);

    // random received bytes, in order
    rxq.delete();
    for (int i = 0; i < 5; i++) begin
      v = 8'($urandom);
      rxq.push_back(v);
      send_byte(v, 1'b0, 1'b0, 1'b0);
    end
    while (rxq.size() > 0) pop_check("rx_rand", rxq.pop_front());
    check("rx_rand_empty", rx_empty, 1);

    // 17 bytes into a 16-deep FIFO
    base = ovf_n;
    n = 0;
    for (int i = 0; i <= DEPTH; i++) begin
      v = 8'(i);
      if (rxq.size() < DEPTH) rxq.push_back(v);
      else n++;
      send_byte(v, 1'b0, 1'b0, 1'b0);
    end
    check("rx_overflow_pulses", ovf_n - base, n);
    while (rxq.size() > 0) pop_check("rx_ovf_data", rxq.pop_front());
    check("rx_ovf_empty", rx_empty, 1);

    // bad stop bit
    base = ferr_n;
    send_byte(8'h3C, 1'b1, 1'b0, 1'b0);
    check("rx_frame_err_pulse", ferr_n - base, 1);
    check("rx_frame_err_empty", rx_empty, 1);

    // echo: received bytes retransmitted and also kept for the host
    echo_en = 1'b1;
    fork
      begin
        send_byte(8'h31, 1'b0, 1'b0, 1'b0);
        send_byte(8'h32, 1'b0, 1'b0, 1'b0);
      end
      begin
        tx_get(4 * NB * BITCLK, got, ok);
        tx_get(4 * NB * BITCLK, got2, ok2);
      end
    join
    echo_en = 1'b0;
    check("echo_ok1", ok, 1);
    check("echo_b1", got, 8'h31);
    check("echo_ok2", ok2, 1);
    check("echo_b2", got2, 8'h32);
    pop_check("echo_rx1", 8'h31);
    pop_check("echo_rx2", 8'h32);
    check("echo_rx_empty", rx_empty, 1);

`ifdef UART_PARITY_EN
    base = perr_n;
    send_byte(8'h07, 1'b0, 1'b1, 1'b0);
    check("par_err_pulse", perr_n - base, 1);
    check("par_err_empty", rx_empty, 1);
    send_byte(8'h07, 1'b0, 1'b0, 1'b0);
    check("par_ok_empty", rx_empty, 0);
    pop_check("par_ok_data", 8'h07);
    base = ferr_n;
    n = perr_n;
    send_byte(8'h07, 1'b1, 1'b1, 1'b0);
    check("par_both_ferr", ferr_n - base, 1);
    check("par_both_no_perr", perr_n - n, 0);
`else
    check("noparity_tied", perr_n, 0);
`endif

    repeat (10) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
